// File: rtl/muldiv_pkg.sv
// Shared types and MIPS funct encodings for the HI/LO multiply/divide controller.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  // Encodings equal funct[1:0] so decode can pass the low funct bits straight through.
  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  function automatic logic is_div_op(input muldiv_op_t o);
    return o[1];
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide step per cycle.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  // acc_hi/acc_lo hold {product upper, product lower} for multiply and {remainder, quotient} for divide.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_diff = rem_sh[WIDTH-1:0] - b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    if (load_i) begin
      acc_hi_d = '0;
      acc_lo_d = a_i;
    end else if (step_i) begin
      if (is_div_i) begin
        acc_hi_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
      end else begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      if (load_i) b_q <= b_i;
    end
  end

  assign acc_hi_o = acc_hi_q;
  assign acc_lo_o = acc_lo_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences multi-cycle MULT/MULTU/DIV/DIVU, services MTHI/MTLO and stalls MFHI/MFLO.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             hilo_read,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output muldiv_state_t    state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  muldiv_op_t       op_q;
  logic             neg_main_q, neg_rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  muldiv_op_t       op_in;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag, core_a, core_b;
  logic             accept, core_load, core_step;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

  // Magnitudes for signed ops; unsigned ops pass raw operands through.
  always_comb begin
    op_in  = muldiv_op_t'(op);
    rs_neg = is_signed_op(op_in) & rs_val[WIDTH-1];
    rt_neg = is_signed_op(op_in) & rt_val[WIDTH-1];
    rs_mag = rs_neg ? -rs_val : rs_val;
    rt_mag = rt_neg ? -rt_val : rt_val;
    core_a = is_div_op(op_in) ? rs_mag : rt_mag;
    core_b = is_div_op(op_in) ? rt_mag : rs_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (cnt_q == CNT_LAST) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start is a one-cycle request taken only in IDLE; stall holds an MFHI/MFLO
  // until the pending result is in HI/LO. start on its own never stalls.
  always_comb begin
    busy      = (state_q != IDLE);
    accept    = start & (state_q == IDLE);
    stall     = hilo_read & (busy | accept);
    core_load = accept;
    core_step = (state_q == ITER);
    done      = done_q;
    state_dbg = state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      op_q       <= MULT;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == FIXUP);
      if (accept) begin
        cnt_q      <= '0;
        op_q       <= op_in;
        neg_main_q <= rs_neg ^ rt_neg;
        neg_rem_q  <= rs_neg;
      end else if (core_step) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (core_load),
    .step_i   (core_step),
    .is_div_i (is_div_op(op_q)),
    .a_i      (core_a),
    .b_i      (core_b),
    .acc_hi_o (acc_hi),
    .acc_lo_o (acc_lo)
  );

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_main_q ? -prod : prod;
    quot_fix = neg_main_q ? -acc_lo : acc_lo;
    rem_fix  = neg_rem_q ? -acc_hi : acc_hi;
    res_hi   = is_div_op(op_q) ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = is_div_op(op_q) ? quot_fix : prod_fix[WIDTH-1:0];
  end

  // An accepted start takes priority over a same-cycle MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == FIXUP) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if ((state_q == IDLE) && !start) begin
      if (mthi) hi_q <= rs_val;
      if (mtlo) lo_q <= rs_val;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed-vector bench for hilo_muldiv_ctrl with hand-computed HI/LO results.
module tb_hilo_muldiv_ctrl;
  import muldiv_pkg::*;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [31:0]   rs_val, rt_val;
  logic          mthi, mtlo, hilo_read;
  logic          busy, done, stall;
  logic [31:0]   hi, lo;
  muldiv_state_t state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hilo_read (hilo_read),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // mode 0: plain op; mode 1: MFHI held, MTHI and a second start during busy;
  // mode 2: MTHI asserted together with the accepted start.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int mode, input logic [31:0] prev_hi);
    int cyc;
    int busy_cnt;
    int done_cnt;
    logic got_done;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    if (mode == 2) mthi = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0;
    if (mode == 1) hilo_read = 1'b1;
    exp_q.push_back(ehi);
    exp_q.push_back(elo);
    cyc = 0; busy_cnt = 0; got_done = 1'b0;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) got_done = 1'b1;
      if (mode == 1) begin
        check({tag, " stall"}, {31'b0, stall}, {31'b0, (cyc <= 33)});
        if (cyc == 7) check({tag, " mthi ignored"}, hi, prev_hi);
        if (cyc == 5) begin rs_val = 32'h0000AAAA; mthi = 1'b1; end
        if (cyc == 6) mthi = 1'b0;
        if (cyc == 10) begin op = MULTU; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1; end
        if (cyc == 11) start = 1'b0;
      end
      if (mode == 2 && cyc == 1) check({tag, " start beats mthi"}, hi, prev_hi);
    end
    check({tag, " latency"}, cyc, 34);
    check({tag, " busy cycles"}, busy_cnt, 33);
    check({tag, " hi"}, hi, exp_q.pop_front());
    check({tag, " lo"}, lo, exp_q.pop_front());
    hilo_read = 1'b0;
    if (mode == 1) begin
      done_cnt = 0;
      busy_cnt = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
      end
      check({tag, " no second done"}, done_cnt, 0);
      check({tag, " no relaunch"}, busy_cnt, 0);
    end
  endtask

  initial begin
    int done_cnt;
    reset = 1'b0; start = 1'b0; op = MULT; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; hilo_read = 1'b0;
    repeat (3) @(negedge clk);
    hilo_read = 1'b1;
    #1;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset state", {30'b0, state_dbg}, {30'b0, IDLE});
    check("idle read no stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    hilo_read = 1'b0;
    @(negedge clk);
    start = 1'b1;
    #1;
    check("start alone no stall", {31'b0, stall}, 32'h0);
    hilo_read = 1'b1;
    #1;
    check("start+read stall", {31'b0, stall}, 32'h1);
    start = 1'b0; hilo_read = 1'b0;

    run_op("multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 32'h0);
    run_op("mult -3x7", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 32'h0);
    run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 32'h0);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 32'h0);
    run_op("divu 100/0", DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 0, 32'h0);
    run_op("div -100/0", DIV, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'h00000001, 0, 32'h0);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 32'h0);

    @(negedge clk);
    rs_val = 32'h00001234; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    #1;
    check("mthi both hi", hi, 32'h00001234);
    check("mtlo both lo", lo, 32'h00001234);
    rs_val = 32'h00000055; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    #1;
    check("mtlo only lo", lo, 32'h00000055);
    check("mtlo only hi", hi, 32'h00001234);

    run_op("divu start+mthi", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 2, 32'h00001234);
    run_op("mult busy traffic", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1, 32'd2);

    @(negedge clk);
    op = DIVU; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort done", {31'b0, done}, 32'h0);
    check("abort state", {30'b0, state_dbg}, {30'b0, IDLE});
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    run_op("multu after abort", MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
